pipeline_hazard_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipelined CPU (IF/ID/EX/MEM/WB).
//  - Owns the enables and flushes of PC, IF/ID, ID/EX and EX/MEM.
//  - Inserts load-use bubbles and flushes wrong-path work on a taken branch or jump.
//  - Freezes the pipe while a peripheral access is pending.
//  - Runs interrupt entry: drains in-flight control transfers, then redirects fetch to 32'h80000004.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/load_use_detect.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions.
//  - state_t: hazard/interrupt sequencer states.
//  - PCSrc encodings that select the next-PC source.
//  - The interrupt vector and the exception-PC register number.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_IRQ_WAIT  = 2'd1,
    ST_IRQ_ENTER = 2'd2
  } state_t;

  localparam logic [2:0] PC_PLUS4 = 3'b000;
  localparam logic [2:0] PC_BR    = 3'b001;
  localparam logic [2:0] PC_J     = 3'b010;
  localparam logic [2:0] PC_JR    = 3'b011;
  localparam logic [2:0] PC_IRQ   = 3'b100;
  localparam logic [2:0] PC_EXC   = 3'b101;

  localparam logic [31:0] IRQ_VECTOR = 32'h80000004;
  localparam logic [4:0]  XP_REG     = 5'd26;

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare: flags an ID instruction that reads the destination of a
// load currently in EX. Purely combinational so the forwarding unit can
// reuse it.
//  rs_i/rt_i          source specifiers of the ID instruction
//  use_rs_i/use_rt_i  ID instruction actually reads that source
//  wr_reg_i           destination of the EX instruction
//  memread_i          EX instruction is a load
//  lu_o               hazard present
module load_use_detect #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rs_i,
  input  logic [REG_W-1:0] rt_i,
  input  logic             use_rs_i,
  input  logic             use_rt_i,
  input  logic [REG_W-1:0] wr_reg_i,
  input  logic             memread_i,
  output logic             lu_o
);

  // $0 is hardwired to zero, so a load into it never creates a dependence.
  assign lu_o = memread_i && (wr_reg_i != '0) &&
                ((use_rs_i && (rs_i == wr_reg_i)) ||
                 (use_rt_i && (rt_i == wr_reg_i)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central sequencer of the 5-stage pipeline. It drives the PC, IF/ID and
// EX/MEM enables and the IF/ID and ID/EX flushes, inserts load-use bubbles,
// squashes wrong-path work on taken branches and jumps, freezes the pipe
// while a peripheral access is outstanding, and sequences interrupt entry.
//  clk_i/reset_i           clock, asynchronous active-high reset
//  rs_id_i..use_rt_id_i    source operands of the ID instruction
//  wr_reg_ex_i/memread_ex_i destination and load flag of the EX instruction
//  branch_taken_ex_i       branch in EX resolved taken
//  jump_id_i               jump decoded in ID
//  mem_wait_i              MEM-stage peripheral access pending
//  irq_i/kernel_id_i       interrupt request / kernel-mode mask
//  pc_en_o, ifid_en_o, exmem_en_o     stage load enables
//  ifid_flush_o, idex_flush_o         bubble insertion
//  irq_take_o              interrupt entry event (PCSrc=PC_IRQ, EPC capture)
//  busy_irq_o              entry sequence in progress
//  stall_cnt_o/flush_cnt_o saturating performance counters
module pipeline_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [REG_W-1:0] rs_id_i,
  input  logic [REG_W-1:0] rt_id_i,
  input  logic             use_rs_id_i,
  input  logic             use_rt_id_i,
  input  logic [REG_W-1:0] wr_reg_ex_i,
  input  logic             memread_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic             jump_id_i,
  input  logic             mem_wait_i,
  input  logic             irq_i,
  input  logic             kernel_id_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             irq_take_o,
  output logic             busy_irq_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu;
  logic             stall_ev;
  logic             hazard;

  load_use_detect #(.REG_W(REG_W)) u_lu (
    .rs_i      (rs_id_i),
    .rt_i      (rt_id_i),
    .use_rs_i  (use_rs_id_i),
    .use_rt_i  (use_rt_id_i),
    .wr_reg_i  (wr_reg_ex_i),
    .memread_i (memread_ex_i),
    .lu_o      (lu)
  );

  // Any condition that must resolve before interrupt entry may proceed.
  assign hazard = branch_taken_ex_i || jump_id_i || lu || mem_wait_i;

  always_comb begin
    state_d      = state_q;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    exmem_en_o   = 1'b1;
    ifid_flush_o = 1'b0;
    idex_flush_o = 1'b0;
    irq_take_o   = 1'b0;
    busy_irq_o   = (state_q != ST_RUN);
    stall_ev     = 1'b0;

    // Hazard priority shared by RUN and IRQ_WAIT. A taken branch wins over
    // lu because the dependent instruction is on the wrong path.
    if (mem_wait_i) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      exmem_en_o = 1'b0;
    end else if (branch_taken_ex_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (lu) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
      stall_ev     = 1'b1;
    end else if (jump_id_i) begin
      ifid_flush_o = 1'b1;
    end

    unique case (state_q)
      ST_RUN: begin
        if (irq_i && !kernel_id_i && !mem_wait_i) state_d = ST_IRQ_WAIT;
      end
      ST_IRQ_WAIT: begin
        // Fetch is frozen unless a control transfer still has to land.
        if (!hazard) begin
          pc_en_o   = 1'b0;
          ifid_en_o = 1'b0;
        end
        if (mem_wait_i)  state_d = ST_IRQ_WAIT;
        else if (!irq_i) state_d = ST_RUN;
        else if (!hazard) state_d = ST_IRQ_ENTER;
      end
      ST_IRQ_ENTER: begin
        // irq_take stays up across a freeze so entry happens exactly once,
        // in the cycle the pipe actually advances.
        irq_take_o = 1'b1;
        stall_ev   = 1'b0;
        if (mem_wait_i) begin
          pc_en_o      = 1'b0;
          ifid_en_o    = 1'b0;
          exmem_en_o   = 1'b0;
          ifid_flush_o = 1'b0;
          idex_flush_o = 1'b0;
        end else begin
          pc_en_o      = 1'b1;
          ifid_en_o    = 1'b1;
          exmem_en_o   = 1'b1;
          ifid_flush_o = 1'b1;
          idex_flush_o = 1'b1;
          state_d      = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (reset_i) begin
      pc_en_o      = 1'b1;
      ifid_en_o    = 1'b1;
      exmem_en_o   = 1'b1;
      ifid_flush_o = 1'b0;
      idex_flush_o = 1'b0;
      irq_take_o   = 1'b0;
      busy_irq_o   = 1'b0;
      stall_ev     = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_ev && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((ifid_flush_o || idex_flush_o) && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  // Expected output vector: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, irq_take, busy_irq}
  localparam logic [6:0] IDLE    = 7'b1100100;
  localparam logic [6:0] STALL   = 7'b0001100;
  localparam logic [6:0] BRF     = 7'b1111100;
  localparam logic [6:0] JMPF    = 7'b1110100;
  localparam logic [6:0] FRZ     = 7'b0000000;
  localparam logic [6:0] W_IDLE  = 7'b0000101;
  localparam logic [6:0] W_BR    = 7'b1111101;
  localparam logic [6:0] W_JMP   = 7'b1110101;
  localparam logic [6:0] W_LU    = 7'b0001101;
  localparam logic [6:0] W_FRZ   = 7'b0000001;
  localparam logic [6:0] ENT     = 7'b1111111;
  localparam logic [6:0] ENT_FRZ = 7'b0000011;

  typedef struct packed {
    logic       rst;
    logic [2:0] hz;
    logic       br, jmp, mw, irq, kern;
    logic [6:0] eo;
  } row_t;

  typedef struct packed {
    logic [6:0]       o;
    logic [CNT_W-1:0] sc;
    logic [CNT_W-1:0] fc;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [REG_W-1:0] rs_id = '0, rt_id = '0, wr_reg_ex = '0;
  logic             use_rs_id = 1'b0, use_rt_id = 1'b0, memread_ex = 1'b0;
  logic             branch_taken_ex = 1'b0, jump_id = 1'b0, mem_wait = 1'b0;
  logic             irq = 1'b0, kernel_id = 1'b0;
  logic             pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, irq_take, busy_irq;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t             sb[$];
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;
  int               checks = 0, failures = 0;

  pipeline_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .rs_id_i           (rs_id),
    .rt_id_i           (rt_id),
    .use_rs_id_i       (use_rs_id),
    .use_rt_id_i       (use_rt_id),
    .wr_reg_ex_i       (wr_reg_ex),
    .memread_ex_i      (memread_ex),
    .branch_taken_ex_i (branch_taken_ex),
    .jump_id_i         (jump_id),
    .mem_wait_i        (mem_wait),
    .irq_i             (irq),
    .kernel_id_i       (kernel_id),
    .pc_en_o           (pc_en),
    .ifid_en_o         (ifid_en),
    .ifid_flush_o      (ifid_flush),
    .idex_flush_o      (idex_flush),
    .exmem_en_o        (exmem_en),
    .irq_take_o        (irq_take),
    .busy_irq_o        (busy_irq),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );

  always #5 clk = ~clk;

  function automatic row_t R(input logic rst, input logic [2:0] hz, input logic br,
                             input logic jmp, input logic mw, input logic irq_r,
                             input logic kern, input logic [6:0] eo);
    return '{rst: rst, hz: hz, br: br, jmp: jmp, mw: mw, irq: irq_r, kern: kern, eo: eo};
  endfunction

  function automatic exp_t obs();
    return '{o: {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, irq_take, busy_irq},
             sc: stall_cnt, fc: flush_cnt};
  endfunction

  // hz: 0 load to $8 with no dependence, 1 lw $8 / add $9,$8,$8,
  //     2 lw $0 / add $9,$0,$0, 3 dependence through rt only,
  //     4 matching fields but not read, 5 matching fields but EX not a load
  task automatic drive(input row_t r);
    @(negedge clk);
    reset = r.rst; branch_taken_ex = r.br; jump_id = r.jmp;
    mem_wait = r.mw; irq = r.irq; kernel_id = r.kern;
    rs_id = 5'd8; rt_id = 5'd8; use_rs_id = 1'b1; use_rt_id = 1'b1;
    wr_reg_ex = 5'd8; memread_ex = 1'b1;
    case (r.hz)
      3'd0: begin rs_id = 5'd1; rt_id = 5'd2; end
      3'd2: begin rs_id = 5'd0; rt_id = 5'd0; wr_reg_ex = 5'd0; end
      3'd3: rs_id = 5'd3;
      3'd4: begin use_rs_id = 1'b0; use_rt_id = 1'b0; end
      3'd5: memread_ex = 1'b0;
      default: ;
    endcase
    if (r.rst) begin m_sc = '0; m_fc = '0; end
    // Counters shown this cycle are the ones accumulated before it.
    sb.push_back('{o: r.eo, sc: m_sc, fc: m_fc});
    if (!r.rst) begin
      if (r.eo[3] && !r.eo[4] && !r.eo[6] && m_sc != '1) m_sc = m_sc + 1'b1;
      if ((r.eo[3] || r.eo[4]) && m_fc != '1) m_fc = m_fc + 1'b1;
    end
  endtask

  task automatic test_reset();
    row_t r[$]; exp_t e, g;
    r.push_back(R(1, 1, 1, 1, 0, 1, 0, IDLE));
    r.push_back(R(1, 0, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL reset row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_load_use();
    row_t r[$]; exp_t e, g;
    r.push_back(R(0, 1, 0, 0, 0, 0, 0, STALL));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 2, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 3, 0, 0, 0, 0, 0, STALL));
    r.push_back(R(0, 4, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 5, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL load_use row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_branch_jump_freeze();
    row_t r[$]; exp_t e, g;
    r.push_back(R(0, 1, 1, 0, 0, 0, 0, BRF));
    r.push_back(R(0, 0, 0, 1, 0, 0, 0, JMPF));
    r.push_back(R(0, 1, 0, 1, 0, 0, 0, STALL));
    r.push_back(R(0, 1, 1, 1, 1, 0, 0, FRZ));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL branch_jump_freeze row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_irq_basic();
    row_t r[$]; exp_t e, g;
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, W_IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, ENT));
    r.push_back(R(0, 0, 0, 0, 0, 1, 1, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL irq_basic row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_irq_hazards();
    row_t r[$]; exp_t e, g;
    // irq with a taken branch: flush first, entry two cycles later
    r.push_back(R(0, 0, 1, 0, 0, 1, 0, BRF));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, W_IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, ENT));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    // jump and load-use resolve inside IRQ_WAIT before entry
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 1, 0, 1, 0, W_JMP));
    r.push_back(R(0, 1, 0, 0, 0, 1, 0, W_LU));
    r.push_back(R(0, 0, 1, 0, 0, 1, 0, W_BR));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, W_IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, ENT));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL irq_hazards row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_irq_mem_wait();
    row_t r[$]; exp_t e, g;
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 1, 1, 0, W_FRZ));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, W_IDLE));
    r.push_back(R(0, 0, 0, 0, 1, 1, 0, ENT_FRZ));
    r.push_back(R(0, 0, 0, 0, 1, 1, 0, ENT_FRZ));
    r.push_back(R(0, 0, 0, 0, 1, 1, 0, ENT_FRZ));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, ENT));
    r.push_back(R(0, 0, 0, 0, 0, 1, 1, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL irq_mem_wait row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_irq_mask_drop_reset();
    row_t r[$]; exp_t e, g;
    // kernel mode masks irq
    r.push_back(R(0, 0, 0, 0, 0, 1, 1, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 1, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 1, IDLE));
    // irq withdrawn during IRQ_WAIT
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, W_IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    // reset while waiting
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 1, 0, W_IDLE));
    r.push_back(R(1, 0, 0, 0, 0, 1, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL irq_mask_drop_reset row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  task automatic test_saturation();
    row_t r[$]; exp_t e, g;
    for (int k = 0; k < 18; k++) r.push_back(R(0, 1, 0, 0, 0, 0, 0, STALL));
    for (int k = 0; k < 3; k++)  r.push_back(R(0, 0, 1, 0, 0, 0, 0, BRF));
    r.push_back(R(0, 0, 0, 0, 0, 0, 0, IDLE));
    foreach (r[i]) begin
      drive(r[i]); #2; e = sb.pop_front(); g = obs(); checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL saturation row%0d: got o=%b sc=%0d fc=%0d, expected o=%b sc=%0d fc=%0d", i, g.o, g.sc, g.fc, e.o, e.sc, e.fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch_jump_freeze();
    test_irq_basic();
    test_irq_hazards();
    test_irq_mem_wait();
    test_irq_mask_drop_reset();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
